de10_nano_input_debounce: RTL and testbench

//  Debounces and synchronises the board KEY/SW pads into the wb_clk domain. Directly feeds the SoC gpio0_i[7:2] bus.
//  Per channel: 2-FF synchroniser, then a stability counter, then a debounced level with rise/fall strobes.

---
 rtl/de10_nano_input_debounce.sv | 119 +++++++++++
 tb/tb_de10_nano_input_debounce.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/de10_nano_input_debounce.sv
// Per-channel 2-FF synchroniser + stability-window debouncer for board KEY/SW pads, with rise/fall strobes.
// Optional rise-interrupt pending logic is built only when DE10_NANO_DEBOUNCE_IRQ_EN is defined.
module de10_nano_input_debounce #(
  parameter int                     WIDTH           = 6,
  parameter int                     CNT_W           = 16,
  parameter int                     DEBOUNCE_CYCLES = 24000,
  parameter logic [WIDTH-1:0]       INVERT          = 6'b000011,
  parameter logic [WIDTH-1:0]       RESET_VAL       = 6'b000011
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] data_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  input  logic [WIDTH-1:0] irq_mask_i,
  input  logic [WIDTH-1:0] irq_clr_i,
  output logic [WIDTH-1:0] irq_pending_o,
  output logic             irq_o
);

  localparam logic [CNT_W-1:0] DC_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0]            sync1_r;
  logic [WIDTH-1:0]            sync2_r;
  logic [WIDTH-1:0]            stable_r;
  logic [WIDTH-1:0]            stable_nxt_s;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_nxt_s;
  logic [WIDTH-1:0]            data_r;
  logic [WIDTH-1:0]            rise_r;
  logic [WIDTH-1:0]            fall_r;
  logic [WIDTH-1:0]            data_nxt_s;
  logic [WIDTH-1:0]            rise_nxt_s;
  logic [WIDTH-1:0]            fall_nxt_s;

  // Two-flop synchroniser for the asynchronous pads
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= RESET_VAL;
      sync2_r <= RESET_VAL;
    end else begin
      sync1_r <= raw_i;
      sync2_r <= sync1_r;
    end
  end

  // Stability window: any return to the stable level restarts the count, so the counter can never wrap
  always_comb begin
    stable_nxt_s = stable_r;
    cnt_nxt_s    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync2_r[i] == stable_r[i]) begin
        cnt_nxt_s[i] = '0;
      end else if (cnt_r[i] == DC_LAST) begin
        stable_nxt_s[i] = sync2_r[i];
        cnt_nxt_s[i]    = '0;
      end else begin
        cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
      end
    end
    data_nxt_s = stable_nxt_s ^ INVERT;
    rise_nxt_s = data_nxt_s & ~data_r;
    fall_nxt_s = ~data_nxt_s & data_r;
  end

  // Debounce state and registered level/strobe outputs
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      stable_r <= RESET_VAL;
      cnt_r    <= '0;
      data_r   <= RESET_VAL ^ INVERT;
      rise_r   <= '0;
      fall_r   <= '0;
    end else begin
      stable_r <= stable_nxt_s;
      cnt_r    <= cnt_nxt_s;
      data_r   <= data_nxt_s;
      rise_r   <= rise_nxt_s;
      fall_r   <= fall_nxt_s;
    end
  end

  assign data_o = data_r;
  assign rise_o = rise_r;
  assign fall_o = fall_r;

`ifdef DE10_NANO_DEBOUNCE_IRQ_EN
  logic [WIDTH-1:0] pending_r;
  logic [WIDTH-1:0] pending_nxt_s;
  logic             irq_r;

  // A rise seen on the strobe outranks a clear arriving in the same cycle
  always_comb begin
    pending_nxt_s = (pending_r & ~irq_clr_i) | (rise_r & irq_mask_i);
  end

  // Pending flags and the registered interrupt line move together
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      pending_r <= '0;
      irq_r     <= 1'b0;
    end else begin
      pending_r <= pending_nxt_s;
      irq_r     <= |pending_nxt_s;
    end
  end

  assign irq_pending_o = pending_r;
  assign irq_o         = irq_r;
`else
  logic unused_irq_s;
  assign unused_irq_s  = ^{irq_mask_i, irq_clr_i};
  assign irq_pending_o = '0;
  assign irq_o         = 1'b0;
`endif

endmodule

// File: tb/tb_de10_nano_input_debounce.sv
// Scoreboard bench for de10_nano_input_debounce with DEBOUNCE_CYCLES=4; works with or without DE10_NANO_DEBOUNCE_IRQ_EN.
module tb_de10_nano_input_debounce;

  localparam int         W   = 6;
  localparam int         DC  = 4;
  localparam logic [5:0] INV = 6'b000011;
  localparam logic [5:0] RV  = 6'b000011;
`ifdef DE10_NANO_DEBOUNCE_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         rst_n;
  logic [W-1:0] raw_i;
  logic [W-1:0] data_o;
  logic [W-1:0] rise_o;
  logic [W-1:0] fall_o;
  logic [W-1:0] irq_mask_i;
  logic [W-1:0] irq_clr_i;
  logic [W-1:0] irq_pending_o;
  logic         irq_o;

  int checks_cnt = 0;
  int errors_cnt = 0;

  typedef struct packed {
    logic [5:0] data;
    logic [5:0] rise;
    logic [5:0] fall;
    logic [5:0] pend;
    logic       irq;
  } obs_t;

  obs_t exp_q[$];

  logic [5:0] m_s1, m_s2, m_stable, m_data, m_rise, m_fall, m_pend;
  logic       m_irq;
  int         m_run[W];

  de10_nano_input_debounce #(
    .WIDTH(W), .CNT_W(16), .DEBOUNCE_CYCLES(DC), .INVERT(INV), .RESET_VAL(RV)
  ) dut (
    .clock(clock), .rst_n(rst_n), .raw_i(raw_i), .data_o(data_o), .rise_o(rise_o),
    .fall_o(fall_o), .irq_mask_i(irq_mask_i), .irq_clr_i(irq_clr_i),
    .irq_pending_o(irq_pending_o), .irq_o(irq_o)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = RV; m_s2 = RV; m_stable = RV; m_data = RV ^ INV;
    m_rise = '0; m_fall = '0; m_pend = '0; m_irq = 1'b0;
    for (int i = 0; i < W; i++) m_run[i] = 0;
  endtask

  // Reference: a level is accepted after DC consecutive cycles of disagreement at the synchroniser output
  task automatic model_step();
    logic [5:0] nd;
    if (!rst_n) begin
      model_reset();
    end else begin
      if (IRQ_ON) begin
        m_pend = (m_pend & ~irq_clr_i) | (m_rise & irq_mask_i);
        m_irq  = |m_pend;
      end
      for (int i = 0; i < W; i++) begin
        if (m_s2[i] != m_stable[i]) begin
          m_run[i]++;
          if (m_run[i] >= DC) begin
            m_stable[i] = m_s2[i];
            m_run[i]    = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      nd     = m_stable ^ INV;
      m_rise = nd & ~m_data;
      m_fall = m_data & ~nd;
      m_data = nd;
      m_s2   = m_s1;
      m_s1   = raw_i;
    end
  endtask

  task automatic tick();
    obs_t e;
    @(posedge clock);
    model_step();
    exp_q.push_back({m_data, m_rise, m_fall, m_pend, m_irq});
    @(negedge clock);
    if (exp_q.size() == 0) begin
      check_eq("sb_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_eq("sb", {data_o, rise_o, fall_o, irq_pending_o, irq_o}, e);
    end
  endtask

  initial begin
    int lat;
    int rise_cnt;
    logic strobe_seen;

    // 1: asynchronous reset values
    rst_n = 1'b0; raw_i = RV; irq_mask_i = '0; irq_clr_i = '0;
    model_reset();
    #2;
    check_eq("rst_data", data_o, 6'b000000);
    check_eq("rst_rise", rise_o, 6'b000000);
    check_eq("rst_fall", fall_o, 6'b000000);
    check_eq("rst_pend", irq_pending_o, 6'b000000);
    check_eq("rst_irq", irq_o, 1'b0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();

    // 2: clean press on KEY0
    raw_i[0] = 1'b0; lat = 0; rise_cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (rise_o[0]) rise_cnt++;
      if (data_o[0] && lat == 0) begin
        lat = k;
        check_eq("press_rise", rise_o[0], 1'b1);
      end
    end
    check_eq("press_lat", lat, 6);
    check_eq("press_rise_cnt", rise_cnt, 1);

    // 3: bounce shorter than the window
    strobe_seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      raw_i[2] = ~raw_i[2];
      repeat (2) begin
        tick();
        strobe_seen |= rise_o[2] | fall_o[2];
      end
    end
    raw_i[2] = 1'b0;
    repeat (8) begin
      tick();
      strobe_seen |= rise_o[2] | fall_o[2] | data_o[2];
    end
    check_eq("bounce_strobe", strobe_seen, 1'b0);
    check_eq("bounce_data", data_o[2], 1'b0);

    // 4: KEY0 release and SW3 (ch5) rise together
    raw_i[0] = 1'b1; raw_i[5] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check_eq("multi_strobe", {fall_o[0], rise_o[5]}, (k == 6) ? 2'b11 : 2'b00);
    end

    // 5: reset in the middle of a count
    raw_i[3] = 1'b1;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check_eq("midrst_data", data_o, 6'b000000);
    check_eq("midrst_rise", rise_o, 6'b000000);
    check_eq("midrst_irq", irq_o, 1'b0);
    repeat (2) tick();
    rst_n = 1'b1; lat = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (data_o[3] && lat == 0) lat = k;
    end
    check_eq("midrst_lat", lat, 6);

    // 6: rise interrupts
    irq_mask_i = 6'b001000;
    raw_i[3] = 1'b0;
    repeat (10) tick();
    raw_i[3] = 1'b1;
    repeat (7) tick();
    check_eq("irq_pend3", irq_pending_o[3], IRQ_ON);
    check_eq("irq_line", irq_o, IRQ_ON);
    repeat (3) tick();
    check_eq("irq_hold", irq_pending_o[3], IRQ_ON);
    irq_clr_i[3] = 1'b1;
    tick();
    irq_clr_i = '0;
    check_eq("irq_cleared", irq_pending_o[3], 1'b0);
    check_eq("irq_line_clr", irq_o, 1'b0);
    raw_i[3] = 1'b0;
    repeat (10) tick();
    raw_i[3] = 1'b1;
    repeat (6) tick();
    check_eq("irq_rise_now", rise_o[3], 1'b1);
    irq_clr_i[3] = 1'b1;
    tick();
    irq_clr_i = '0;
    check_eq("irq_set_wins", irq_pending_o[3], IRQ_ON);
    raw_i[2] = 1'b1;
    repeat (10) tick();
    check_eq("irq_masked_ch2", irq_pending_o[2], 1'b0);
    irq_clr_i = 6'b111111;
    tick();
    irq_clr_i = '0;
    tick();
    check_eq("irq_all_clr", irq_o, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
